// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int BCD_NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    // ceil(w * log10(2)); the integer approximation is exact for w = 1..64
    function automatic int bcd_digits(input int w);
        return (w * 301 + 999) / 1000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single-nibble double-dabble correction: nibbles of 5 or more get +3 before the shift.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] nib,
    output logic [BCD_NIBBLE_W-1:0] nib_adj
);

    always_comb begin
        nib_adj = nib;
        if (nib >= BCD_NIBBLE_W'(5)) begin
            nib_adj = nib + BCD_NIBBLE_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/ready/valid handshake.
// Optional two's-complement input (sign + magnitude) when BIN2BCD_SIGNED_EN is defined.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = bcd_digits(BIN_W)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [BIN_W-1:0]             bin_in,
    output logic                         ready,
    output logic                         valid,
    output logic [4*DIGITS-1:0]          bcd_out,
    output logic                         sign
);

    localparam int BCD_W = DIGITS * BCD_NIBBLE_W;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    if (DIGITS < bcd_digits(BIN_W)) begin : g_digits_chk
        $error("bin2bcd_seq: DIGITS is too small to hold a BIN_W-bit value");
    end
    if (BIN_W < 1 || BIN_W > 64) begin : g_width_chk
        $error("bin2bcd_seq: BIN_W must be within 1..64");
    end

    bcd_state_e        state_p0, state_nxt;
    logic [SR_W-1:0]   sr_p0;
    logic [SR_W-1:0]   sr_adj;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CNT_W-1:0]  cnt_p0;
    logic [BIN_W-1:0]  mag;
    logic              accept;

    assign accept = (state_p0 == IDLE) && start;
    assign ready  = (state_p0 == IDLE);

`ifdef BIN2BCD_SIGNED_EN
    // -(-2^(BIN_W-1)) wraps to 2^(BIN_W-1), which is the correct unsigned magnitude
    function automatic logic [BIN_W-1:0] abs_mag(input logic signed [BIN_W-1:0] v);
        logic signed [BIN_W-1:0] neg;
        neg = -v;
        return v[BIN_W-1] ? $unsigned(neg) : $unsigned(v);
    endfunction

    logic sign_p0, sign_p1;

    assign mag  = abs_mag(bin_in);
    assign sign = sign_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_p0 <= 1'b0;
            sign_p1 <= 1'b0;
        end else begin
            if (accept) begin
                sign_p0 <= bin_in[BIN_W-1];
            end
            if (state_p0 == DONE) begin
                sign_p1 <= sign_p0;
            end
        end
    end
`else
    assign mag  = bin_in;
    assign sign = 1'b0;
`endif

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .nib     (sr_p0[BIN_W + d*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .nib_adj (bcd_adj[d*BCD_NIBBLE_W +: BCD_NIBBLE_W])
        );
    end

    assign sr_adj = {bcd_adj, sr_p0[BIN_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt_p0 == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage boundary: shift register load / correct-and-shift / result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_p0   <= '0;
            cnt_p0  <= '0;
            bcd_out <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_p0)
                IDLE: begin
                    if (start) begin
                        sr_p0  <= {{BCD_W{1'b0}}, mag};
                        cnt_p0 <= '0;
                    end
                end
                SHIFT: begin
                    sr_p0  <= sr_adj << 1;
                    cnt_p0 <= cnt_p0 + CNT_W'(1);
                end
                DONE: begin
                    bcd_out <= sr_p0[SR_W-1 -: BCD_W];
                    valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
